// File: rtl/bp_stall_profiler_ctrl_pkg.sv
// Shared types for the stall-profiler control/readout sequencer:
// command and state encodings, dump header layout, and the drop-counter helper.
package bp_stall_prof_pkg;

   typedef enum logic [1:0] {
      CMD_START = 2'd0,
      CMD_STOP  = 2'd1,
      CMD_DUMP  = 2'd2,
      CMD_CLEAR = 2'd3
   } bp_stall_prof_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } bp_stall_prof_state_e;

   // Word 0 of every dump; packed MSB-first into the low 32 bits of the stream word.
   typedef struct packed {
      logic [15:0] seq;
      logic [7:0]  dropped;
      logic [7:0]  num;
   } bp_stall_prof_hdr_s;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

endpackage

// File: rtl/bp_stall_profiler_ctrl_if.sv
// Host-facing handshakes of the profiler: command port and dump word stream.
interface bp_stall_profiler_ctrl_if #(
   parameter int cnt_width_p = 32
);
   logic                   cmd_v_i;
   logic [1:0]             cmd_i;
   logic                   cmd_ready_o;
   logic [cnt_width_p-1:0] data_o;
   logic                   data_v_o;
   logic                   data_ready_i;
   logic                   last_o;

   modport slave (
      input  cmd_v_i, cmd_i, data_ready_i,
      output cmd_ready_o, data_o, data_v_o, last_o
   );

   modport master (
      output cmd_v_i, cmd_i, data_ready_i,
      input  cmd_ready_o, data_o, data_v_o, last_o
   );
endinterface

// File: rtl/bp_stall_profiler_ctrl_timer.sv
// Auto-dump interval counter: runs while enabled with a nonzero period and
// pulses expire_o on the cycle the count reaches interval-1.
module bp_stall_prof_timer #(
   parameter int interval_width_p = 32
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        en_i,
   input  logic                        clr_i,
   input  logic [interval_width_p-1:0] interval_i,
   output logic                        expire_o
);
   localparam logic [interval_width_p-1:0] ZERO_C = {interval_width_p{1'b0}};
   localparam logic [interval_width_p-1:0] ONE_C  = {{(interval_width_p-1){1'b0}}, 1'b1};

   logic [interval_width_p-1:0] r_timer;
   logic                        w_run;

   assign w_run    = en_i & (interval_i != ZERO_C);
   // Equality (not >=) so a period shrunk below the count wraps the full range.
   assign expire_o = w_run & (r_timer == (interval_i - ONE_C));

   // Interval count register: clear wins, expiry restarts, otherwise count or hold.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_timer <= ZERO_C;
      end else if (clr_i || expire_o) begin
         r_timer <= ZERO_C;
      end else if (w_run) begin
         r_timer <= r_timer + ONE_C;
      end else begin
         r_timer <= r_timer;
      end
   end

endmodule

// File: rtl/bp_stall_profiler_ctrl.sv
// Stall-counter bank sequencer: start/stop/clear control, atomic snapshot and
// header-prefixed drain over valid/ready, periodic auto-dump with drop counting.
module bp_stall_profiler_ctrl
   import bp_stall_prof_pkg::*;
#(
   parameter int num_reasons_p    = 24,
   parameter int cnt_width_p      = 32,
   parameter int interval_width_p = 32
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   bp_stall_profiler_ctrl_if.slave              bus,
   input  logic [interval_width_p-1:0]          interval_i,
   input  logic [num_reasons_p*cnt_width_p-1:0] cnt_i,
   output logic                                 count_en_o,
   output logic                                 clear_o,
   output logic                                 busy_o
);
   localparam logic [7:0]             NUM_C   = 8'(num_reasons_p);
   localparam logic [cnt_width_p-1:0] WZERO_C = {cnt_width_p{1'b0}};

   bp_stall_prof_state_e r_state, w_state_nxt;
   bp_stall_prof_cmd_e   w_cmd;

   logic [num_reasons_p*cnt_width_p-1:0] r_shadow;
   logic [7:0]                           r_index;
   logic [15:0]                          r_seq;
   logic [7:0]                           r_dropped;
   logic                                 r_count_en;
   logic [cnt_width_p-1:0]               r_data;
   logic                                 r_last;

   logic                   w_cmd_acc, w_hs, w_expire, w_dump, w_drop, w_timer_clr, w_en_nxt;
   logic [7:0]             w_sel;
   logic [cnt_width_p-1:0] w_shadow_word, w_hdr_word;
   bp_stall_prof_hdr_s     w_hdr;

   assign w_cmd     = bp_stall_prof_cmd_e'(bus.cmd_i);
   assign w_cmd_acc = bus.cmd_v_i & (r_state == ST_IDLE);
   assign w_hs      = (r_state == ST_DRAIN) & bus.data_ready_i;

   // r_index == NUM_C has no shadow entry; the select is parked on 0 there.
   assign w_sel         = (r_index < NUM_C) ? r_index : 8'd0;
   assign w_shadow_word = r_shadow[w_sel*cnt_width_p +: cnt_width_p];

   // Header for the dump being accepted, zero-extended to the stream width.
   always_comb begin
      w_hdr.seq        = r_seq;
      w_hdr.dropped    = r_dropped;
      w_hdr.num        = NUM_C;
      w_hdr_word       = WZERO_C;
      w_hdr_word[31:0] = w_hdr;
   end

   bp_stall_prof_timer #(.interval_width_p(interval_width_p)) u_timer (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .en_i       (r_count_en),
      .clr_i      (w_timer_clr),
      .interval_i (interval_i),
      .expire_o   (w_expire)
   );

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, command decode and trigger arbitration (expiry merges into a dump).
   always_comb begin
      w_state_nxt = r_state;
      w_dump      = 1'b0;
      w_drop      = 1'b0;
      w_timer_clr = 1'b0;
      w_en_nxt    = r_count_en;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_acc) begin
               case (w_cmd)
                  CMD_START: begin
                     w_en_nxt    = 1'b1;
                     w_timer_clr = 1'b1;
                     w_drop      = w_expire;
                  end
                  CMD_STOP: begin
                     w_en_nxt = 1'b0;
                     w_drop   = w_expire;
                  end
                  CMD_DUMP: begin
                     w_dump      = 1'b1;
                     w_state_nxt = ST_DRAIN;
                  end
                  CMD_CLEAR: begin
                     w_timer_clr = 1'b1;
                     w_drop      = w_expire;
                     w_state_nxt = ST_CLEAR;
                  end
                  default: w_state_nxt = ST_IDLE;
               endcase
            end else if (w_expire) begin
               w_dump      = 1'b1;
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            w_drop = w_expire;
            if (w_hs && (r_index == NUM_C)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_CLEAR: begin
            w_drop      = w_expire;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Snapshot, drain index, registered stream word/last and dump sequence number.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_shadow <= {(num_reasons_p*cnt_width_p){1'b0}};
         r_index  <= 8'd0;
         r_data   <= WZERO_C;
         r_last   <= 1'b0;
         r_seq    <= 16'd0;
      end else if (w_dump) begin
         r_shadow <= cnt_i;
         r_index  <= 8'd0;
         r_data   <= w_hdr_word;
         r_last   <= 1'b0;
      end else if (w_hs) begin
         if (r_index == NUM_C) begin
            r_index <= 8'd0;
            r_data  <= WZERO_C;
            r_last  <= 1'b0;
            r_seq   <= r_seq + 16'd1;
         end else begin
            r_index <= r_index + 8'd1;
            r_data  <= w_shadow_word;
            r_last  <= ((r_index + 8'd1) == NUM_C);
         end
      end
   end

   // Dropped-trigger counter; the header handshake restarts it (at 1 on a same-cycle drop).
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_dropped <= 8'd0;
      end else if (w_hs && (r_index == 8'd0)) begin
         r_dropped <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop) begin
         r_dropped <= sat_inc8(r_dropped);
      end
   end

   // Counting enable for the counter bank.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_count_en <= 1'b0;
      end else begin
         r_count_en <= w_en_nxt;
      end
   end

   assign bus.cmd_ready_o = (r_state == ST_IDLE);
   assign bus.data_v_o    = (r_state == ST_DRAIN);
   assign bus.data_o      = r_data;
   assign bus.last_o      = r_last;
   assign clear_o         = (r_state == ST_CLEAR);
   assign busy_o          = (r_state != ST_IDLE);
   assign count_en_o      = r_count_en;

endmodule

// File: doc/bp_stall_profiler_ctrl.md
# bp_stall_profiler_ctrl

Control and readout sequencer for the per-core stall-reason counter bank. Accepts host commands to start/stop counting, clear, and dump. It snapshots all counters atomically and drains them as a header-prefixed word stream over valid/ready. An optional periodic timer triggers dumps automatically, and trigger overruns are counted and reported. Sits between the stall-counter bank (gated by `count_en_o`, cleared by `clear_o`) and the host-facing FIFO or shell bridge.

## Interface
- `num_reasons_p`, 24: number of stall-reason counters; 1..255.
- `cnt_width_p`, 32: counter and stream word width; must be ≥32.
- `interval_width_p`, 32: periodic-interval register width.
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `cmd_v_i`  in  1  command valid.
- `cmd_i`  in  2  command: 0 start, 1 stop, 2 dump, 3 clear.
- `cmd_ready_o`  out  1  command accepted when `cmd_v_i & cmd_ready_o`.
- `interval_i`  in  `interval_width_p`  auto-dump period in cycles; 0 disables the timer.
- `cnt_i`  in  `num_reasons_p*cnt_width_p`  live counter values; reason k is at `[k*cnt_width_p +: cnt_width_p]`.
- `count_en_o`  out  1  enables counting in the counter bank.
- `clear_o`  out  1  one-cycle clear pulse to the counter bank.
- `data_o`  out  `cnt_width_p`  stream word.
- `data_v_o`  out  1  stream valid.
- `data_ready_i`  in  1  stream ready.
- `last_o`  out  1  marks the final word of a dump.
- `busy_o`  out  1  high when not in IDLE.

## Operation
- **States:** IDLE, DRAIN, CLEAR. `cmd_ready_o` = (state==IDLE).
- **start:** `count_en_o` is set to 1; timer is set to 0.
- **stop:** `count_en_o` is set to 0. The timer holds while `count_en_o`=0.
- **clear:** enters CLEAR. `clear_o`=1 during the CLEAR cycle, then returns to IDLE. Timer is set to 0. `count_en_o` is unchanged.
- **dump:** on the accept edge, shadow[k] is loaded from `cnt_i` and the state moves to DRAIN with index=0.
- **DRAIN stream:**
  - index 0 is the header: `{zero-ext, seq[15:0], dropped[7:0], num_reasons_p[7:0]}`.
  - index j (1..`num_reasons_p`) carries shadow[j-1].
  - index advances on `data_v_o & data_ready_i`.
  - `last_o` = (index == `num_reasons_p`).
  - After the last handshake: return to IDLE and increment `seq` (16-bit, wraps).
- **Periodic timer:**
  - Counts only while `count_en_o`=1 and `interval_i`≠0.
  - Expires when timer == `interval_i`-1. On expiry the timer returns to 0.
  - Expiry in IDLE with no `cmd_v_i`: behaves exactly like an accepted dump.
- **Dropped triggers:**
  - An expiry in DRAIN or CLEAR increments `dropped`; it saturates at 255.
  - An expiry in IDLE together with an accepted start, stop or clear: the command is taken and `dropped` increments.
  - An expiry together with an accepted dump: merged into one dump, no drop.
- **dropped clearing:** the header handshake clears `dropped`. If a drop occurs in that same cycle, `dropped` becomes 1.
- **Stall from the stream:** `data_ready_i` low holds `data_o`, `last_o` and index stable.

## Timing
- **Reset values:**
  - state IDLE: `cmd_ready_o`=1.
  - `count_en_o`=0, `clear_o`=0, `data_v_o`=0, `last_o`=0, `data_o`=0, `busy_o`=0.
  - seq=0, dropped=0, timer=0.
- **Latency:**
  - Dump accepted at cycle T: snapshot holds `cnt_i` as seen in T. Header is valid at T+1.
  - With ready held high, the last word is at T+1+`num_reasons_p` and IDLE returns at T+2+`num_reasons_p`.
  - Start/stop accepted at T: `count_en_o` changes at T+1.
  - Clear accepted at T: `clear_o` is high in T+1, and `cmd_ready_o` is high again at T+2.
- **Outputs:** `data_v_o` = (state==DRAIN). All outputs are registered or decoded from state only; none depend combinationally on `cmd_v_i` or `data_ready_i`.
- **Mid-operation reset:** asynchronous assertion mid-DRAIN aborts immediately with `data_v_o`=0. Deassertion is synchronised externally.
- **Interval change:** changing `interval_i` while running takes effect at the next comparison. If the new value is ≤ the current timer, the timer wraps through its full range before expiring.

## Structure
- **Package `bp_stall_prof_pkg`:** command enum `bp_stall_prof_cmd_e`, state enum, and header struct `bp_stall_prof_hdr_s` (seq, dropped, num).
- **Sub-module `bp_stall_prof_timer`:** interval counter with enable, clear and expiry output.
- **Shadow bank:** a flat register array read through an index mux.

## Test plan
- **Basic dump:** reset, start, wait 10 cycles, dump with `cnt_i`=k+1 per reason and ready=1 → header `{seq 0, dropped 0, num 24}` at T+1, words 1..24, `last_o` on the 24th, `busy_o` low at T+26.
- **Backpressure:** ready toggles 1-0-0-1 during drain → no word skipped or duplicated, `data_o` stable while ready=0, `cnt_i` changing mid-drain does not affect output.
- **Periodic:** `interval_i`=50, start, ready=1 → dumps begin every 50 cycles with seq 0,1,2. Then hold ready=0 for 200 cycles → next header shows dropped=4.
- **Simultaneous events:** an expiry coinciding with an accepted dump → a single dump with dropped=0. An expiry coinciding with a clear → `clear_o` pulses and the next header shows dropped=1.
- **Clear and commands:** clear → `clear_o` high for exactly one cycle with `count_en_o` unchanged. Stop → the timer freezes and no auto dump occurs for 500 cycles. Any command during DRAIN → `cmd_ready_o`=0 and the command is not taken.
- **Reset mid-drain:** assert `reset_n_i` low at word 5 → `data_v_o`=0 immediately. After release: IDLE, seq=0, `count_en_o`=0.
